// File: rtl/hilo_div_pkg.sv
// Shared types and constants for the HI/LO divide sequencer.
package hilo_div_pkg;

  localparam int HILO_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_DIVZERO = 2'b01,
    ST_ON      = 2'b10,
    ST_END     = 2'b11
  } div_state_e;

  localparam logic [HILO_WIDTH-1:0] DIVZERO_QUO = {HILO_WIDTH{1'b1}};

endpackage

// File: rtl/hilo_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module hilo_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;

  always_comb begin
    trial = {i_rem, i_bit};
    diff  = {1'b0, trial} - {2'b00, i_divisor};
    // A set top bit means the subtraction borrowed: restore the trial value.
    o_q   = ~diff[WIDTH+1];
    o_rem = diff[WIDTH+1] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer driving the HI/LO write path.
// Optional HILO_DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for i_start, operands captured on accept
// ST_DIVZERO | divisor was zero, one filler cycle
// ST_ON      | iterating, one quotient bit per cycle
// ST_END     | result on o_hi/o_lo, o_done/o_whilo pulse
module hilo_div_ctrl
  import hilo_div_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_cancel,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_whilo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  hilo_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (rem_q),
    .i_divisor (dvs_q),
    .i_bit     (quo_q[WIDTH-1]),
    .o_rem     (step_rem),
    .o_q       (step_q)
  );

  always_comb begin
    a_mag = (i_signed && i_dividend[WIDTH-1]) ? (-i_dividend) : i_dividend;
    b_mag = (i_signed && i_divisor[WIDTH-1])  ? (-i_divisor)  : i_divisor;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_cancel) begin
          dvs_d   = b_mag;
          quo_d   = a_mag;
          rem_d   = '0;
          cnt_d   = '0;
          q_neg_d = i_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
          r_neg_d = i_signed & i_dividend[WIDTH-1];
          if (i_divisor == '0) begin
            // Raw dividend parked in rem so DIVZERO can report it unmodified.
            state_d = ST_DIVZERO;
            rem_d   = i_dividend;
          end
`ifdef HILO_DIV_EARLY_OUT_EN
          else if (a_mag < b_mag) begin
            state_d = ST_END;
            hi_d    = i_dividend;
            lo_d    = '0;
          end
`endif
          else begin
            state_d = ST_ON;
          end
        end
      end
      ST_ON: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = ST_END;
          lo_d    = q_neg_q ? (-quo_d) : quo_d;
          hi_d    = r_neg_q ? (-rem_d) : rem_d;
        end
      end
      ST_DIVZERO: begin
        state_d = ST_END;
        lo_d    = DIVZERO_QUO[WIDTH-1:0];
        hi_d    = rem_q;
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (i_cancel) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    o_stall = ((state_q == ST_IDLE) && i_start && !i_cancel) ||
              (((state_q == ST_ON) || (state_q == ST_DIVZERO)) && !i_cancel);
    o_busy  = busy_q;
    o_done  = done_q;
    o_whilo = done_q;
    o_hi    = hi_q;
    o_lo    = lo_q;
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: cycle-level arithmetic model plus directed literal checks.
module tb_hilo_div_ctrl;
  import hilo_div_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic         i_signed = 1'b0;
  logic [W-1:0] i_dividend = '0;
  logic [W-1:0] i_divisor = '0;
  logic         i_cancel = 1'b0;
  logic         o_stall, o_busy, o_done, o_whilo;
  logic [W-1:0] o_hi, o_lo;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  hilo_div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_signed   (i_signed),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_cancel   (i_cancel),
    .o_stall    (o_stall),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_whilo    (o_whilo),
    .o_hi       (o_hi),
    .o_lo       (o_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Expected result and END latency straight from the arithmetic definition.
  function automatic void model_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] lo, output logic [W-1:0] hi,
                                    output int lat);
    longint sa, sb, q, r, ma, mb;
    if (b == '0) begin
      lo  = '1;
      hi  = a;
      lat = 2;
    end else begin
      sa  = s ? longint'($signed(a)) : longint'(a);
      sb  = s ? longint'($signed(b)) : longint'(b);
      q   = sa / sb;
      r   = sa % sb;
      lo  = W'(q);
      hi  = W'(r);
      lat = W + 1;
      ma  = (sa < 0) ? -sa : sa;
      mb  = (sb < 0) ? -sb : sb;
`ifdef HILO_DIV_EARLY_OUT_EN
      if (ma < mb) lat = 1;
`else
      if (ma < mb) lat = W + 1;
`endif
    end
  endfunction

  // Per-cycle model: an accepted divide occupies [start, end]; END is at end.
  int           cyc = 0;
  bit           m_active = 1'b0;
  int           m_start = 0;
  int           m_end = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit           e_idle, e_busy, e_done, e_stall;
  int           e_lat;

  always @(negedge clk) begin
    e_idle  = !m_active || (cyc > m_end);
    e_busy  = m_active && (cyc > m_start) && (cyc <= m_end);
    e_done  = m_active && (cyc == m_end);
    e_stall = (e_idle && i_start && !i_cancel) ||
              (m_active && (cyc > m_start) && (cyc < m_end) && !i_cancel);
    if (e_done) begin
      m_hi = p_hi;
      m_lo = p_lo;
    end
    if (chk_en) begin
      check("m_busy",  W'(o_busy),  W'(e_busy));
      check("m_done",  W'(o_done),  W'(e_done));
      check("m_whilo", W'(o_whilo), W'(e_done));
      check("m_stall", W'(o_stall), W'(e_stall));
      check("m_hi",    o_hi,        m_hi);
      check("m_lo",    o_lo,        m_lo);
    end
    if (rst) begin
      m_active = 1'b0;
      m_hi     = '0;
      m_lo     = '0;
    end else if (e_idle && i_start && !i_cancel) begin
      model_div(i_signed, i_dividend, i_divisor, p_lo, p_hi, e_lat);
      m_active = 1'b1;
      m_start  = cyc;
      m_end    = cyc + e_lat;
    end else if (e_busy && !e_done && i_cancel) begin
      m_active = 1'b0;
    end
    cyc++;
  end

  task automatic wait_done(output int n);
    n = 0;
    while (o_done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_div(input string name, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] elo,
                         input logic [W-1:0] ehi, input int elat);
    int n;
    @(posedge clk); #1;
    i_start = 1'b1; i_signed = s; i_dividend = a; i_divisor = b;
    #1;
    check({name, "_stall0"}, W'(o_stall), W'(1));
    wait_done(n);
    i_start = 1'b0;
    check({name, "_lat"}, W'(n), W'(elat));
    check({name, "_lo"}, o_lo, elo);
    check({name, "_hi"}, o_hi, ehi);
    @(posedge clk); #1;
    check({name, "_whilo_drop"}, W'(o_whilo), W'(0));
  endtask

  int n1;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", W'(o_busy), W'(0));
    check("rst_done", W'(o_done), W'(0));
    check("rst_hi", o_hi, '0);
    check("rst_lo", o_lo, '0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, DIVZERO_QUO, 32'd5, 2);
    run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 33);
`ifdef HILO_DIV_EARLY_OUT_EN
    run_div("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1);
`else
    run_div("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 33);
`endif

    // Cancel at cycle 10 of a long divide, then restart.
    @(posedge clk); #1;
    i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    i_cancel = 1'b1;
    #1;
    check("cancel_stall", W'(o_stall), W'(0));
    @(posedge clk); #1;
    i_cancel = 1'b0; i_start = 1'b0;
    check("cancel_busy", W'(o_busy), W'(0));
    check("cancel_done", W'(o_done), W'(0));
    check("cancel_lo_hold", o_lo, 32'd0);
    repeat (30) begin @(posedge clk); #1; end
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Back-to-back: i_start held through END.
    @(posedge clk); #1;
    i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd20; i_divisor = 32'd6;
    wait_done(n1);
    check("b2b1_lat", W'(n1), W'(33));
    check("b2b1_lo", o_lo, 32'd3);
    check("b2b1_hi", o_hi, 32'd2);
    i_dividend = 32'd50; i_divisor = 32'd8;
    @(posedge clk); #1;
    check("b2b2_idle_busy", W'(o_busy), W'(0));
    check("b2b2_idle_stall", W'(o_stall), W'(1));
    wait_done(n1);
    i_start = 1'b0;
    check("b2b2_lat", W'(n1), W'(33));
    check("b2b2_lo", o_lo, 32'd6);
    check("b2b2_hi", o_hi, 32'd2);

    // Synchronous reset in the middle of an operation.
    @(posedge clk); #1;
    i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; i_start = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", W'(o_busy), W'(0));
    check("midrst_done", W'(o_done), W'(0));
    check("midrst_stall", W'(o_stall), W'(0));
    check("midrst_hi", o_hi, '0);
    check("midrst_lo", o_lo, '0);
    rst = 1'b0;
    run_div("divu_post_rst", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 33);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
